// File: rtl/frame_mem_arbiter.sv
// Round-robin arbiter sharing one frame-memory port between NUM_REQ drawing engines.
// Registers the winner into a single output stage and steers in-order read returns back by tag.
module frame_mem_arbiter #(
  parameter int NUM_REQ     = 3,
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 16,
  parameter int MAX_RD      = 4,
  parameter int LOG2_MAX_RD = 2
) (
  input  logic                          clk,
  input  logic                          rst_,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*4-1:0]          req_wben,
  input  logic [NUM_REQ-1:0]            req_op,
  input  logic [NUM_REQ-1:0]            req_rts,
  output logic [NUM_REQ-1:0]            req_rtr,
  output logic [DATA_WIDTH-1:0]         req_rd_data,
  output logic [NUM_REQ-1:0]            req_rd_valid,
  output logic [DATA_WIDTH-1:0]         mem_data,
  output logic [ADDR_WIDTH-1:0]         mem_addr,
  output logic [3:0]                    mem_wben,
  output logic                          mem_op,
  output logic                          mem_rts,
  input  logic                          mem_rtr,
  input  logic [DATA_WIDTH-1:0]         mem_rd_data,
  input  logic                          mem_rd_valid,
  output logic                          err_unexp_rd
);
  localparam int IDW = $clog2(NUM_REQ);
  localparam logic [LOG2_MAX_RD:0] MAX_RD_C = (LOG2_MAX_RD+1)'(MAX_RD);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [ADDR_WIDTH-1:0] addr;
    logic [3:0]            wben;
    logic                  op;
    logic [IDW-1:0]        id;
  } stage_t;

  stage_t                       stg_q, stg_d;
  logic                         stg_v_q, stg_v_d;
  logic [IDW-1:0]               ptr_q, ptr_d;
  logic [MAX_RD-1:0][IDW-1:0]   tag_q, tag_d;
  logic [LOG2_MAX_RD-1:0]       wp_q, wp_d, rp_q, rp_d;
  logic [LOG2_MAX_RD:0]         fcnt_q, fcnt_d, rd_cnt_q, rd_cnt_d;
  logic [DATA_WIDTH-1:0]        rd_data_q, rd_data_d;
  logic [NUM_REQ-1:0]           rd_vld_q, rd_vld_d;
  logic                         err_q, err_d;

  logic [NUM_REQ-1:0] elig;
  logic               can_load, found, req_xfer, mem_xfer, push, pop, rd_inc;
  int                 win_i;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++)
      elig[i] = req_rts[i] & (req_op[i] | (rd_cnt_q < MAX_RD_C));
  end

  // Scan upward from the pointer; first eligible requester wins.
  always_comb begin
    can_load = !stg_v_q | mem_rtr;
    found    = 1'b0;
    win_i    = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && elig[(int'(ptr_q) + k) % NUM_REQ]) begin
        found = 1'b1;
        win_i = (int'(ptr_q) + k) % NUM_REQ;
      end
    end
    req_xfer = found & can_load;
    req_rtr  = '0;
    for (int i = 0; i < NUM_REQ; i++)
      req_rtr[i] = req_xfer & ~rst_ & (win_i == i);
  end

  always_comb begin
    stg_d   = stg_q;
    stg_v_d = stg_v_q;
    ptr_d   = ptr_q;
    if (can_load) begin
      stg_v_d = req_xfer;
      if (req_xfer) begin
        stg_d.data = req_data[win_i*DATA_WIDTH +: DATA_WIDTH];
        stg_d.addr = req_addr[win_i*ADDR_WIDTH +: ADDR_WIDTH];
        stg_d.wben = req_wben[win_i*4 +: 4];
        stg_d.op   = req_op[win_i];
        stg_d.id   = IDW'(win_i);
        ptr_d      = IDW'((win_i + 1) % NUM_REQ);
      end
    end

    mem_xfer = stg_v_q & mem_rtr;
    push     = mem_xfer & ~stg_q.op;
    // Pop sees only the pre-edge count, so a same-cycle push into an empty FIFO is not poppable.
    pop      = mem_rd_valid & (fcnt_q != '0);
    rd_inc   = req_xfer & ~req_op[win_i];

    tag_d = tag_q;
    wp_d  = wp_q;
    rp_d  = rp_q;
    if (push) begin
      tag_d[wp_q] = stg_q.id;
      wp_d        = wp_q + 1'b1;
    end
    if (pop) rp_d = rp_q + 1'b1;
    fcnt_d   = fcnt_q + {{LOG2_MAX_RD{1'b0}}, push} - {{LOG2_MAX_RD{1'b0}}, pop};
    rd_cnt_d = rd_cnt_q + {{LOG2_MAX_RD{1'b0}}, rd_inc} - {{LOG2_MAX_RD{1'b0}}, pop};

    rd_data_d = pop ? mem_rd_data : rd_data_q;
    rd_vld_d  = '0;
    for (int i = 0; i < NUM_REQ; i++)
      rd_vld_d[i] = pop & (tag_q[rp_q] == IDW'(i));
    err_d = err_q | (mem_rd_valid & (fcnt_q == '0));
  end

  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      stg_q     <= '0;
      stg_v_q   <= 1'b0;
      ptr_q     <= '0;
      tag_q     <= '0;
      wp_q      <= '0;
      rp_q      <= '0;
      fcnt_q    <= '0;
      rd_cnt_q  <= '0;
      rd_data_q <= '0;
      rd_vld_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      stg_q     <= stg_d;
      stg_v_q   <= stg_v_d;
      ptr_q     <= ptr_d;
      tag_q     <= tag_d;
      wp_q      <= wp_d;
      rp_q      <= rp_d;
      fcnt_q    <= fcnt_d;
      rd_cnt_q  <= rd_cnt_d;
      rd_data_q <= rd_data_d;
      rd_vld_q  <= rd_vld_d;
      err_q     <= err_d;
    end
  end

  assign mem_data     = stg_q.data;
  assign mem_addr     = stg_q.addr;
  assign mem_wben     = stg_q.wben;
  assign mem_op       = stg_q.op;
  assign mem_rts      = stg_v_q;
  assign req_rd_data  = rd_data_q;
  assign req_rd_valid = rd_vld_q;
  assign err_unexp_rd = err_q;
endmodule
